// File: rtl/cdiv_issuer.sv
// cdiv_issuer: gathers NUM_OPERANDS stream words into one divider operand vector,
// issues it under a credit limit, and re-serialises each {real, imag} result as two words.
module cdiv_issuer #(
    parameter int WIDTH           = 64,
    parameter int NUM_OPERANDS    = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    output logic                          flush_o,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [WIDTH-1:0]              s_data_i,
    output logic                          op_valid_o,
    input  logic                          op_ready_i,
    output logic [NUM_OPERANDS*WIDTH-1:0] op_operands_o,
    input  logic                          res_valid_i,
    output logic                          res_ready_o,
    input  logic [2*WIDTH-1:0]            res_result_i,
    input  logic [4:0]                    res_status_i,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [WIDTH-1:0]              m_data_o,
    output logic                          m_last_o,
    output logic [4:0]                    m_status_o,
    output logic                          busy_o
);
    localparam int IW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_OPERANDS - 1);
    localparam logic [CW-1:0] MAX_CREDIT = CW'(MAX_OUTSTANDING);

    typedef enum logic {GATHER, ISSUE} gather_t;
    typedef enum logic [1:0] {RX, TX_RE, TX_IM} result_t;

    gather_t                     r_gState;
    logic [IW-1:0]               r_idx;
    logic [NUM_OPERANDS*WIDTH-1:0] r_operands;
    logic                        r_opValid;
    logic [CW-1:0]               r_outstanding;

    result_t                     r_rState;
    logic [WIDTH-1:0]            r_real;
    logic [WIDTH-1:0]            r_imag;
    logic [4:0]                  r_status;
    logic                        r_mValid;
    logic                        r_mLast;

    logic                        w_sHs;
    logic                        w_opHs;
    logic                        w_resHs;
    logic                        w_mHs;
    logic [CW-1:0]               w_outNext;
    gather_t                     w_gNext;

    // Flush gates both readies so no new word or result can land during it.
    assign flush_o     = flush_i;
    assign s_ready_o   = (r_gState == GATHER) && !flush_i;
    assign res_ready_o = (r_rState == RX) && !flush_i;

    assign w_sHs   = s_valid_i && s_ready_o;
    assign w_opHs  = r_opValid && op_ready_i;
    assign w_resHs = res_valid_i && res_ready_o;
    assign w_mHs   = r_mValid && m_ready_i;

    always_comb begin
        w_outNext = r_outstanding;
        if (w_opHs && !w_resHs)
            w_outNext = r_outstanding + CW'(1);
        else if (w_resHs && !w_opHs && (r_outstanding != '0))
            w_outNext = r_outstanding - CW'(1);

        w_gNext = r_gState;
        if ((r_gState == GATHER) && w_sHs && (r_idx == LAST_IDX))
            w_gNext = ISSUE;
        else if ((r_gState == ISSUE) && w_opHs)
            w_gNext = GATHER;
    end

    // op_valid is computed from next-state credit so it rises the cycle after the last word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gState      <= GATHER;
            r_idx         <= '0;
            r_operands    <= '0;
            r_opValid     <= 1'b0;
            r_outstanding <= '0;
        end else if (flush_i) begin
            r_gState      <= GATHER;
            r_idx         <= '0;
            r_opValid     <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_gState      <= w_gNext;
            r_outstanding <= w_outNext;
            r_opValid     <= (w_gNext == ISSUE) && (w_outNext < MAX_CREDIT);
            if (w_sHs) begin
                r_operands[r_idx*WIDTH +: WIDTH] <= s_data_i;
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rState <= RX;
            r_real   <= '0;
            r_imag   <= '0;
            r_status <= '0;
            r_mValid <= 1'b0;
            r_mLast  <= 1'b0;
        end else if (flush_i) begin
            r_rState <= RX;
            r_mValid <= 1'b0;
            r_mLast  <= 1'b0;
        end else begin
            case (r_rState)
                RX: if (w_resHs) begin
                    r_real   <= res_result_i[WIDTH-1:0];
                    r_imag   <= res_result_i[2*WIDTH-1:WIDTH];
                    r_status <= res_status_i;
                    r_mValid <= 1'b1;
                    r_mLast  <= 1'b0;
                    r_rState <= TX_RE;
                end
                TX_RE: if (w_mHs) begin
                    r_mLast  <= 1'b1;
                    r_rState <= TX_IM;
                end
                TX_IM: if (w_mHs) begin
                    r_mValid <= 1'b0;
                    r_mLast  <= 1'b0;
                    r_rState <= RX;
                end
                default: r_rState <= RX;
            endcase
        end
    end

    assign op_valid_o    = r_opValid;
    assign op_operands_o = r_operands;
    assign m_valid_o     = r_mValid;
    assign m_data_o      = r_mLast ? r_imag : r_real;
    assign m_last_o      = r_mLast;
    assign m_status_o    = r_status;
    assign busy_o        = (r_idx != '0) || (r_gState == ISSUE) ||
                           (r_outstanding != '0) || (r_rState != RX);

endmodule
